priority_finder_rr: RTL and testbench



---
 rtl/priority_finder_rr.sv | 114 +++++++++++
 tb/tb_priority_finder_rr.sv | 132 +++++++++++++
 2 files changed

// File: rtl/priority_finder_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | priority_finder_rr                                                   |
// | Multi-grant priority finder (fixed-low/fixed-high/round-robin) with  |
// | a registered valid/ready output stage and flush.                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module priority_finder_rr #(
  parameter int WIDTH     = 16,
  parameter int GRANT_NUM = 2,
  parameter int MODE      = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic [WIDTH-1:0]                            req,
  input  logic                                        grant_ready,
  output logic [GRANT_NUM-1:0]                        grant_valid,
  output logic [GRANT_NUM-1:0][$clog2(WIDTH)-1:0]     grant_index,
  output logic [WIDTH-1:0]                            grant_mask,
  output logic [$clog2(GRANT_NUM+1)-1:0]              grant_count
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(GRANT_NUM+1);

  logic [GRANT_NUM-1:0]          r_valid;
  logic [GRANT_NUM-1:0][IW-1:0]  r_index;
  logic [WIDTH-1:0]              r_mask;
  logic [CW-1:0]                 r_count;
  logic [IW-1:0]                 r_ptr;

  logic [GRANT_NUM-1:0]          w_sel_valid;
  logic [GRANT_NUM-1:0][IW-1:0]  w_sel_index;
  logic [WIDTH-1:0]              w_sel_mask;
  logic [CW-1:0]                 w_sel_count;
  logic [IW-1:0]                 w_pos;
  int                            w_taken;
  logic [IW-1:0]                 w_last;
  logic                          w_load;
  logic                          w_fire;

  // Walk the scan order once; each hit fills the next free lane.
  always_comb begin
    w_sel_valid = '0;
    w_sel_index = '0;
    w_sel_mask  = '0;
    w_sel_count = '0;
    w_pos       = '0;
    w_taken     = 0;
    for (int p = 0; p < WIDTH; p++) begin
      if (MODE == 0)
        w_pos = IW'(p);
      else if (MODE == 1)
        w_pos = IW'(WIDTH - 1 - p);
      else
        w_pos = r_ptr + IW'(p);
      if (req[w_pos] && (w_taken < GRANT_NUM)) begin
        for (int k = 0; k < GRANT_NUM; k++) begin
          if (k == w_taken) begin
            w_sel_valid[k] = 1'b1;
            w_sel_index[k] = w_pos;
          end
        end
        w_sel_mask[w_pos] = 1'b1;
        w_taken = w_taken + 1;
      end
    end
    w_sel_count = CW'(w_taken);
  end

  // Lanes are contiguous, so the last valid lane is the highest-numbered one.
  always_comb begin
    w_last = '0;
    for (int k = 0; k < GRANT_NUM; k++) begin
      if (r_valid[k])
        w_last = r_index[k];
    end
  end

  assign w_load = !r_valid[0] || grant_ready;
  assign w_fire = r_valid[0] && grant_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_index <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_ptr   <= '0;
    end else begin
      if ((MODE == 2) && w_fire)
        r_ptr <= w_last + IW'(1);
      if (flush) begin
        r_valid <= '0;
        r_index <= '0;
        r_mask  <= '0;
        r_count <= '0;
      end else if (w_load) begin
        r_valid <= w_sel_valid;
        r_index <= w_sel_index;
        r_mask  <= w_sel_mask;
        r_count <= w_sel_count;
      end
    end
  end

  assign grant_valid = r_valid;
  assign grant_index = r_index;
  assign grant_mask  = r_mask;
  assign grant_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_priority_finder_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_priority_finder_rr                                                |
// | Directed bench: round-robin instance plus fixed-low/high instances.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_priority_finder_rr;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [7:0]       req;
  logic             ready;
  logic [7:0]       req_f;
  logic             ready_f;

  logic [1:0]       v2, v1, v0;
  logic [1:0][2:0]  i2, i1, i0;
  logic [7:0]       m2, m1, m0;
  logic [1:0]       c2, c1, c0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  priority_finder_rr #(.WIDTH(8), .GRANT_NUM(2), .MODE(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req(req), .grant_ready(ready),
    .grant_valid(v2), .grant_index(i2), .grant_mask(m2), .grant_count(c2));

  priority_finder_rr #(.WIDTH(8), .GRANT_NUM(2), .MODE(1)) dut_hi (
    .clk(clk), .rst(rst), .flush(flush), .req(req_f), .grant_ready(ready_f),
    .grant_valid(v1), .grant_index(i1), .grant_mask(m1), .grant_count(c1));

  priority_finder_rr #(.WIDTH(8), .GRANT_NUM(2), .MODE(0)) dut_lo (
    .clk(clk), .rst(rst), .flush(flush), .req(req_f), .grant_ready(ready_f),
    .grant_valid(v0), .grant_index(i0), .grant_mask(m0), .grant_count(c0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output-stage check of the round-robin instance plus its pointer.
  task automatic chk_rr(input string tag, input logic [1:0] ev, input logic [2:0] e0,
                        input logic [2:0] e1, input logic [7:0] em, input logic [1:0] ec,
                        input logic [2:0] ep);
    chk({tag, ".valid"}, 32'(v2), 32'(ev));
    chk({tag, ".idx0"},  32'(i2[0]), 32'(e0));
    chk({tag, ".idx1"},  32'(i2[1]), 32'(e1));
    chk({tag, ".mask"},  32'(m2), 32'(em));
    chk({tag, ".count"}, 32'(c2), 32'(ec));
    chk({tag, ".ptr"},   32'(dut.r_ptr), 32'(ep));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; req = 8'hFF; ready = 1'b1;
    req_f = 8'h16; ready_f = 1'b1;
    tick(); tick();
    chk_rr("reset", 2'b00, 3'd0, 3'd0, 8'h00, 2'd0, 3'd0);
    chk("reset.hi_valid", 32'(v1), 32'h0);
    chk("reset.lo_valid", 32'(v0), 32'h0);

    rst = 1'b1;
    tick();
    chk_rr("post_reset", 2'b11, 3'd0, 3'd1, 8'h03, 2'd2, 3'd0);

    // Fixed-order instances have loaded req_f=8'h16 (bits 1,2,4).
    chk("hi.idx0", 32'(i1[0]), 32'd4);
    chk("hi.idx1", 32'(i1[1]), 32'd2);
    chk("hi.mask", 32'(m1), 32'h14);
    chk("hi.ptr",  32'(dut_hi.r_ptr), 32'd0);
    chk("lo.idx0", 32'(i0[0]), 32'd1);
    chk("lo.idx1", 32'(i0[1]), 32'd2);
    chk("lo.mask", 32'(m0), 32'h06);
    chk("lo.ptr",  32'(dut_lo.r_ptr), 32'd0);

    // Round-robin with req held; each capture uses the pre-fire pointer.
    req = 8'b1010_0110;
    tick(); chk_rr("rr1", 2'b11, 3'd1, 3'd2, 8'h06, 2'd2, 3'd2);
    tick(); chk_rr("rr2", 2'b11, 3'd2, 3'd5, 8'h24, 2'd2, 3'd3);
    tick(); chk_rr("rr3", 2'b11, 3'd5, 3'd7, 8'hA0, 2'd2, 3'd6);
    tick(); chk_rr("rr4", 2'b11, 3'd7, 3'd1, 8'h82, 2'd2, 3'd0);

    // Stall: outputs and pointer hold while req changes.
    ready = 1'b0; req = 8'h80;
    tick(); chk_rr("stall1", 2'b11, 3'd7, 3'd1, 8'h82, 2'd2, 3'd0);
    tick(); chk_rr("stall2", 2'b11, 3'd7, 3'd1, 8'h82, 2'd2, 3'd0);
    tick(); chk_rr("stall3", 2'b11, 3'd7, 3'd1, 8'h82, 2'd2, 3'd0);
    ready = 1'b1;
    tick(); chk_rr("unstall", 2'b01, 3'd7, 3'd0, 8'h80, 2'd1, 3'd2);

    // Wrap: firing lane index 7 returns ptr to 0.
    req = 8'b1000_0001;
    tick(); chk_rr("wrap1", 2'b11, 3'd7, 3'd0, 8'h81, 2'd2, 3'd0);
    tick(); chk_rr("wrap2", 2'b11, 3'd0, 3'd7, 8'h81, 2'd2, 3'd1);

    // Empty request: load without fire leaves ptr alone.
    req = 8'h06;
    tick(); chk_rr("pre_empty", 2'b11, 3'd1, 3'd2, 8'h06, 2'd2, 3'd0);
    req = 8'h00;
    tick(); chk_rr("empty1", 2'b00, 3'd0, 3'd0, 8'h00, 2'd0, 3'd3);
    tick(); chk_rr("empty2", 2'b00, 3'd0, 3'd0, 8'h00, 2'd0, 3'd3);

    // Flush while stalled.
    req = 8'h06;
    tick(); chk_rr("pre_flush", 2'b11, 3'd1, 3'd2, 8'h06, 2'd2, 3'd3);
    ready = 1'b0; flush = 1'b1;
    tick(); chk_rr("flush_stall", 2'b00, 3'd0, 3'd0, 8'h00, 2'd0, 3'd3);
    flush = 1'b0; req = 8'h10;
    tick(); chk_rr("refill", 2'b01, 3'd4, 3'd0, 8'h10, 2'd1, 3'd3);

    // Flush coincident with fire still advances the pointer.
    ready = 1'b1; flush = 1'b1;
    tick(); chk_rr("flush_fire", 2'b00, 3'd0, 3'd0, 8'h00, 2'd0, 3'd5);
    flush = 1'b0;
    tick(); chk_rr("after_flush", 2'b01, 3'd4, 3'd0, 8'h10, 2'd1, 3'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
